map_wram_guard: RTL and testbench
=================================

// Module: map_wram_guard
// PURPOSE
//  Parametrised on-cart work-RAM window controller for MMC6-class mappers; generalises the 2x512B protected RAM.
//  Maps N banks into a mirrored 4KB CPU window and gates each bank by per-bank read/write enables.
//  Enables live in a protect reg, cleared while a master bit in a ctrl reg is low.
//  Sits beside the MMC3 core; drives srm.ce/oe/we/addr and the mapper's internal zero-data OE.
// PARAMETERS
//  BANKS       2      number of RAM banks, 1..4; bank i uses prot bits WE=PL+2i, RE=PL+2i+1, PL=8-2*BANKS
//  BANK_AW     9      bank size 2^BANK_AW bytes; BANK_AW+clog2(BANKS) <= 12
//  WIN_BASE    4'h7   cpu_addr[15:12] value selecting the window
//  CTRL_RA     4'h8   {A15:13,A0} code of ctrl register
//  PROT_RA     4'hB   {A15:13,A0} code of protect register
//  MASTER_BIT  5      ctrl bit that enables RAM; 0 forces prot to 0
//  LOCKOUT     4      M2 falling edges after reset during which RAM writes are blocked; 0 = none
//  SST_BASE    32     save-state address of ctrl; prot at SST_BASE+1
// PORTS
//  clk         in   1        mapper clock (mai.clk)
//  rst         in   1        synchronous active-high reset (mai.map_rst)
//  cpu_addr    in   16       CPU address
//  cpu_data    in   8        CPU write data
//  cpu_rw      in   1        1=read, 0=write
//  cpu_m2      in   1        CPU M2, synchronous to clk
//  sst_act     in   1        save-state engine active
//  sst_we_reg  in   1        save-state register write strobe
//  sst_addr    in   8        save-state register address
//  sst_dato    in   8        save-state write data
//  sst_di      out  8        save-state read data; 8'hFF when !sst_hit
//  sst_hit     out  1        sst_addr is SST_BASE or SST_BASE+1
//  srm_ce      out  1        RAM bank selected and read-enabled
//  srm_oe      out  1        =cpu_rw
//  srm_we      out  1        write strobe
//  srm_addr    out  BANK_AW+clog2(BANKS)  {bank, offset} into SRAM
//  zero_oe     out  1        window read with no enabled bank: mapper drives 8'h00
//  ctrl_q      out  8        ctrl register
//  prot_q      out  8        protect register
// BEHAVIOUR
//  - Reset: ctrl_q=0, prot_q=0, lockout cnt=LOCKOUT, m2_d=0; outputs follow combinationally (srm_ce=srm_we=0).
//  - m2_d<=cpu_m2 each clk; fall = m2_d & !cpu_m2. All register updates happen only on a clk with fall (1-clk latency).
//  - On fall, priority: rst > sst_act > CPU. sst_act: sst_we_reg at SST_BASE/+1 loads ctrl/prot; CPU writes ignored.
//  - CPU write (!cpu_rw) at CTRL_RA loads ctrl_q. If ctrl_q[MASTER_BIT]==0 (old value), prot_q<=0.
//    Else CPU write at PROT_RA loads prot_q. Ctrl write enabling master allows prot writes from the next fall.
//  - Window hit: cpu_addr[15:12]==WIN_BASE. bank=cpu_addr[BANK_AW +: clog2(BANKS)]; bank>=BANKS is unmapped.
//  - srm_ce = hit & mapped & RE[bank]. srm_we = hit & mapped & WE[bank] & !cpu_rw & cpu_m2 & lock_cnt==0.
//  - A write needs WE only: srm_we is asserted even when RE=0, as on MMC6.
//  - zero_oe = hit & cpu_rw & !srm_ce. srm_addr = cpu_addr[BANK_AW+clog2(BANKS)-1:0].
//  - lock_cnt decrements on each fall and saturates at 0. Reset mid-frame reloads LOCKOUT.
//  - lock_cnt affects writes only; reads are never blocked.
//  - Simultaneous fall + rst: rst wins. sst_act during lockout: lock_cnt still counts.
// CONFIGURATION
//  WRAM_SST_EN defined: save-state port live as described.
//  WRAM_SST_EN undefined: sst_* inputs ignored, sst_hit=0, sst_di=8'hFF, no sst mux logic.
// STRUCTURE
//  Package map_wram_pkg:
//   - prot_we_idx(i,BANKS) / prot_re_idx(i,BANKS) functions
//   - reg-addr code constants CTRL_RA/PROT_RA defaults
//   - SST offset constants
//  Sub-module wram_bank_dec: one instance per bank via generate.
//   - In: hit, bank match, prot bits.
//   - Out: ce_i, we_i, OR-reduced at top.
// TESTING
//  1 BANKS=2, LOCKOUT=0: write ctrl=8'h20, prot=8'hF0; read $7000 -> srm_ce=1, srm_addr=0; read $7200 -> srm_addr=10'h200.
//  2 Master off: ctrl=8'h00, then prot write 8'hF0 -> prot_q stays 8'h00; read $7000 -> zero_oe=1.
//  3 prot=8'h10 (bank0 WE only): write $7005 -> srm_we=1 while M2 high, srm_ce=0; read $7005 -> zero_oe=1.
//  4 LOCKOUT=4: after rst, writes in M2 cycles 1-4 -> srm_we=0; 5th cycle -> srm_we=1.
//  5 BANKS=3: read $7600 (bank 3) with prot=8'hFC -> srm_ce=0, zero_oe=1.
//  6 WRAM_SST_EN: sst_act, sst_we_reg@32=8'h20, @33=8'hC0 -> ctrl_q/prot_q loaded; CPU write ignored; sst_di@33=8'hC0, @40=8'hFF.

Source files
------------

// File: rtl/map_wram_pkg.sv
// Shared constants and protect-bit index helpers for the MMC6-style work-RAM guard.
package map_wram_pkg;

    localparam int unsigned PROT_W       = 8;
    localparam logic [3:0]  CTRL_RA_DEF  = 4'h8;
    localparam logic [3:0]  PROT_RA_DEF  = 4'hB;
    localparam int unsigned SST_CTRL_OFS = 0;
    localparam int unsigned SST_PROT_OFS = 1;

    // Banks pack into the top of the protect byte as {RE,WE} pairs.
    function automatic int unsigned prot_we_idx(input int unsigned i, input int unsigned banks);
        return (PROT_W - 2 * banks) + 2 * i;
    endfunction

    function automatic int unsigned prot_re_idx(input int unsigned i, input int unsigned banks);
        return (PROT_W - 2 * banks) + 2 * i + 1;
    endfunction

endpackage

// File: rtl/wram_bank_dec.sv
// Per-bank chip-enable / write-strobe decode for one work-RAM bank.
module wram_bank_dec (
    input  logic i_hit,
    input  logic i_bank_match,
    input  logic i_prot_re,
    input  logic i_prot_we,
    input  logic i_wr_ok,
    output logic o_ce,
    output logic o_we
);

    // Write strobe needs only WE; a write-only bank still accepts stores.
    assign o_ce = i_hit & i_bank_match & i_prot_re;
    assign o_we = i_hit & i_bank_match & i_prot_we & i_wr_ok;

endmodule

// File: rtl/map_wram_guard.sv
// Work-RAM window controller: mirrored 4KB window, per-bank RE/WE protection, power-up write lockout.
// Optional save-state port enabled by defining WRAM_SST_EN.
module map_wram_guard
    import map_wram_pkg::*;
#(
    parameter int unsigned BANKS      = 2,
    parameter int unsigned BANK_AW    = 9,
    parameter logic [3:0]  WIN_BASE   = 4'h7,
    parameter logic [3:0]  CTRL_RA    = CTRL_RA_DEF,
    parameter logic [3:0]  PROT_RA    = PROT_RA_DEF,
    parameter int unsigned MASTER_BIT = 5,
    parameter int unsigned LOCKOUT    = 4,
    parameter int unsigned SST_BASE   = 32,
    localparam int unsigned SRM_AW    = BANK_AW + $clog2(BANKS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_cpu_addr,
    input  logic [7:0]        i_cpu_data,
    input  logic              i_cpu_rw,
    input  logic              i_cpu_m2,
    input  logic              i_sst_act,
    input  logic              i_sst_we_reg,
    input  logic [7:0]        i_sst_addr,
    input  logic [7:0]        i_sst_dato,
    output logic [7:0]        o_sst_di,
    output logic              o_sst_hit,
    output logic              o_srm_ce,
    output logic              o_srm_oe,
    output logic              o_srm_we,
    output logic [SRM_AW-1:0] o_srm_addr,
    output logic              o_zero_oe,
    output logic [7:0]        o_ctrl_q,
    output logic [7:0]        o_prot_q
);

    localparam int unsigned BSEL_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int unsigned LCW    = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    logic              r_m2_d;
    logic [7:0]        r_ctrl;
    logic [PROT_W-1:0] r_prot;
    logic [LCW-1:0]    r_lock;

    logic              w_fall;
    logic              w_hit;
    logic              w_wr_ok;
    logic              w_cpu_wr;
    logic [3:0]        w_ra;
    logic [BSEL_W-1:0] w_bank;
    logic [BANKS-1:0]  w_ce_v;
    logic [BANKS-1:0]  w_we_v;
    logic              w_sst_act;
    logic              w_sst_ctrl;
    logic              w_sst_prot;
    logic              w_unused;

    assign w_fall   = r_m2_d & ~i_cpu_m2;
    assign w_hit    = (i_cpu_addr[15:12] == WIN_BASE);
    assign w_ra     = {i_cpu_addr[15:13], i_cpu_addr[0]};
    assign w_cpu_wr = ~i_cpu_rw;
    assign w_wr_ok  = ~i_cpu_rw & i_cpu_m2 & (r_lock == '0);

    generate
        if (BANKS > 1) begin : g_bsel
            assign w_bank = i_cpu_addr[BANK_AW +: BSEL_W];
        end else begin : g_bsel_one
            assign w_bank = '0;
        end

        for (genvar g = 0; g < BANKS; g++) begin : g_bank
            wram_bank_dec u_dec (
                .i_hit        (w_hit),
                .i_bank_match (w_bank == BSEL_W'(g)),
                .i_prot_re    (r_prot[3'(prot_re_idx(g, BANKS))]),
                .i_prot_we    (r_prot[3'(prot_we_idx(g, BANKS))]),
                .i_wr_ok      (w_wr_ok),
                .o_ce         (w_ce_v[g]),
                .o_we         (w_we_v[g])
            );
        end
    endgenerate

    assign o_srm_ce   = |w_ce_v;
    assign o_srm_we   = |w_we_v;
    assign o_srm_oe   = i_cpu_rw;
    assign o_zero_oe  = w_hit & i_cpu_rw & ~o_srm_ce;
    assign o_srm_addr = i_cpu_addr[SRM_AW-1:0];
    assign o_ctrl_q   = r_ctrl;
    assign o_prot_q   = r_prot;

`ifdef WRAM_SST_EN
    assign w_sst_act  = i_sst_act;
    assign w_sst_ctrl = i_sst_we_reg & (i_sst_addr == 8'(SST_BASE + SST_CTRL_OFS));
    assign w_sst_prot = i_sst_we_reg & (i_sst_addr == 8'(SST_BASE + SST_PROT_OFS));
    assign w_unused   = ^i_cpu_addr;

    // Save-state readback of ctrl/prot.
    always_comb begin
        o_sst_hit = 1'b0;
        o_sst_di  = 8'hFF;
        if (i_sst_addr == 8'(SST_BASE + SST_CTRL_OFS)) begin
            o_sst_hit = 1'b1;
            o_sst_di  = r_ctrl;
        end else if (i_sst_addr == 8'(SST_BASE + SST_PROT_OFS)) begin
            o_sst_hit = 1'b1;
            o_sst_di  = r_prot;
        end
    end
`else
    assign w_sst_act  = 1'b0;
    assign w_sst_ctrl = 1'b0;
    assign w_sst_prot = 1'b0;
    assign o_sst_hit  = 1'b0;
    assign o_sst_di   = 8'hFF;
    assign w_unused   = ^{i_cpu_addr, i_sst_act, i_sst_we_reg, i_sst_addr, i_sst_dato};
`endif

    // All register state advances only on an M2 falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m2_d <= 1'b0;
            r_ctrl <= '0;
            r_prot <= '0;
            r_lock <= LCW'(LOCKOUT);
        end else begin
            r_m2_d <= i_cpu_m2;
            if (w_fall) begin
                if (r_lock != '0) begin
                    r_lock <= r_lock - 1'b1;
                end
                if (w_sst_act) begin
                    if (w_sst_ctrl) r_ctrl <= i_sst_dato;
                    if (w_sst_prot) r_prot <= i_sst_dato;
                end else begin
                    if (w_cpu_wr && (w_ra == CTRL_RA)) r_ctrl <= i_cpu_data;
                    // Master-off clears protect using the pre-write ctrl value.
                    if (!r_ctrl[MASTER_BIT]) begin
                        r_prot <= '0;
                    end else if (w_cpu_wr && (w_ra == PROT_RA)) begin
                        r_prot <= i_cpu_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_map_wram_guard.sv
// Directed bench for map_wram_guard: three configurations share one CPU/save-state stimulus bus.
module tb_map_wram_guard;

`ifdef WRAM_SST_EN
    localparam bit SST_ON = 1'b1;
`else
    localparam bit SST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_rw, cpu_m2;
    logic        sst_act, sst_we_reg;
    logic [7:0]  sst_addr, sst_dato;

    logic [7:0]  d0_sst_di, d1_sst_di, d2_sst_di;
    logic        d0_sst_hit, d1_sst_hit, d2_sst_hit;
    logic        d0_ce, d0_oe, d0_we, d0_zoe;
    logic        d1_ce, d1_oe, d1_we, d1_zoe;
    logic        d2_ce, d2_oe, d2_we, d2_zoe;
    logic [9:0]  d0_addr, d1_addr;
    logic [10:0] d2_addr;
    logic [7:0]  d0_ctrl, d0_prot, d1_ctrl, d1_prot, d2_ctrl, d2_prot;

    logic        c0_ce, c0_we, c0_zoe, c0_oe, c1_ce, c1_we, c2_ce, c2_zoe;
    logic [9:0]  c0_addr;
    logic [10:0] c2_addr;

    int checks = 0;
    int errors = 0;

    map_wram_guard #(.BANKS(2), .BANK_AW(9), .LOCKOUT(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
        .i_cpu_rw(cpu_rw), .i_cpu_m2(cpu_m2), .i_sst_act(sst_act), .i_sst_we_reg(sst_we_reg),
        .i_sst_addr(sst_addr), .i_sst_dato(sst_dato), .o_sst_di(d0_sst_di), .o_sst_hit(d0_sst_hit),
        .o_srm_ce(d0_ce), .o_srm_oe(d0_oe), .o_srm_we(d0_we), .o_srm_addr(d0_addr),
        .o_zero_oe(d0_zoe), .o_ctrl_q(d0_ctrl), .o_prot_q(d0_prot));

    map_wram_guard #(.BANKS(2), .BANK_AW(9), .LOCKOUT(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
        .i_cpu_rw(cpu_rw), .i_cpu_m2(cpu_m2), .i_sst_act(sst_act), .i_sst_we_reg(sst_we_reg),
        .i_sst_addr(sst_addr), .i_sst_dato(sst_dato), .o_sst_di(d1_sst_di), .o_sst_hit(d1_sst_hit),
        .o_srm_ce(d1_ce), .o_srm_oe(d1_oe), .o_srm_we(d1_we), .o_srm_addr(d1_addr),
        .o_zero_oe(d1_zoe), .o_ctrl_q(d1_ctrl), .o_prot_q(d1_prot));

    map_wram_guard #(.BANKS(3), .BANK_AW(9), .LOCKOUT(0)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_cpu_addr(cpu_addr), .i_cpu_data(cpu_data),
        .i_cpu_rw(cpu_rw), .i_cpu_m2(cpu_m2), .i_sst_act(sst_act), .i_sst_we_reg(sst_we_reg),
        .i_sst_addr(sst_addr), .i_sst_dato(sst_dato), .o_sst_di(d2_sst_di), .o_sst_hit(d2_sst_hit),
        .o_srm_ce(d2_ce), .o_srm_oe(d2_oe), .o_srm_we(d2_we), .o_srm_addr(d2_addr),
        .o_zero_oe(d2_zoe), .o_ctrl_q(d2_ctrl), .o_prot_q(d2_prot));

    // One CPU bus cycle: M2 high for one clk (outputs captured), then the falling edge commits.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rw);
        @(negedge clk);
        cpu_addr = a; cpu_data = d; cpu_rw = rw; cpu_m2 = 1'b1;
        @(negedge clk);
        c0_ce = d0_ce; c0_we = d0_we; c0_zoe = d0_zoe; c0_oe = d0_oe; c0_addr = d0_addr;
        c1_ce = d1_ce; c1_we = d1_we;
        c2_ce = d2_ce; c2_zoe = d2_zoe; c2_addr = d2_addr;
        cpu_m2 = 1'b0;
        @(negedge clk);
        cpu_rw = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_addr = 16'h7000; cpu_rw = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (d0_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h exp 00", d0_ctrl); end
        checks++; if (d0_prot !== 8'h00) begin errors++; $display("FAIL reset_prot got %h exp 00", d0_prot); end
        checks++; if (d1_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl1 got %h exp 00", d1_ctrl); end
        checks++; if (d0_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", d0_ce); end
        checks++; if (d0_zoe !== 1'b1) begin errors++; $display("FAIL reset_zoe got %b exp 1", d0_zoe); end
        checks++; if (d0_oe !== 1'b1) begin errors++; $display("FAIL reset_oe got %b exp 1", d0_oe); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bus(16'h8000, 8'h20, 1'b0);
        bus(16'hA001, 8'hF0, 1'b0);
        checks++; if (d0_ctrl !== 8'h20) begin errors++; $display("FAIL basic_ctrl got %h exp 20", d0_ctrl); end
        checks++; if (d0_prot !== 8'hF0) begin errors++; $display("FAIL basic_prot got %h exp F0", d0_prot); end
        bus(16'h7000, 8'h00, 1'b1);
        checks++; if (c0_ce !== 1'b1) begin errors++; $display("FAIL rd7000_ce got %b exp 1", c0_ce); end
        checks++; if (c0_addr !== 10'h000) begin errors++; $display("FAIL rd7000_addr got %h exp 000", c0_addr); end
        checks++; if (c0_zoe !== 1'b0) begin errors++; $display("FAIL rd7000_zoe got %b exp 0", c0_zoe); end
        bus(16'h7200, 8'h00, 1'b1);
        checks++; if (c0_ce !== 1'b1) begin errors++; $display("FAIL rd7200_ce got %b exp 1", c0_ce); end
        checks++; if (c0_addr !== 10'h200) begin errors++; $display("FAIL rd7200_addr got %h exp 200", c0_addr); end
        bus(16'h7600, 8'h00, 1'b1);
        checks++; if (c0_addr !== 10'h200) begin errors++; $display("FAIL mirror_addr got %h exp 200", c0_addr); end
        bus(16'h7201, 8'h3C, 1'b0);
        checks++; if (c0_we !== 1'b1) begin errors++; $display("FAIL wr7201_we got %b exp 1", c0_we); end
        checks++; if (c0_oe !== 1'b0) begin errors++; $display("FAIL wr7201_oe got %b exp 0", c0_oe); end
        bus(16'h6000, 8'h00, 1'b1);
        checks++; if (c0_ce !== 1'b0) begin errors++; $display("FAIL rd6000_ce got %b exp 0", c0_ce); end
        checks++; if (c0_zoe !== 1'b0) begin errors++; $display("FAIL rd6000_zoe got %b exp 0", c0_zoe); end
    endtask

    task automatic test_master_off();
        bus(16'h8000, 8'h00, 1'b0);
        bus(16'hA001, 8'hF0, 1'b0);
        checks++; if (d0_ctrl !== 8'h00) begin errors++; $display("FAIL moff_ctrl got %h exp 00", d0_ctrl); end
        checks++; if (d0_prot !== 8'h00) begin errors++; $display("FAIL moff_prot got %h exp 00", d0_prot); end
        bus(16'h7000, 8'h00, 1'b1);
        checks++; if (c0_zoe !== 1'b1) begin errors++; $display("FAIL moff_zoe got %b exp 1", c0_zoe); end
        checks++; if (c0_ce !== 1'b0) begin errors++; $display("FAIL moff_ce got %b exp 0", c0_ce); end
    endtask

    task automatic test_we_only();
        bus(16'h8000, 8'h20, 1'b0);
        bus(16'hA001, 8'h10, 1'b0);
        checks++; if (d0_prot !== 8'h10) begin errors++; $display("FAIL weo_prot got %h exp 10", d0_prot); end
        bus(16'h7005, 8'h5A, 1'b0);
        checks++; if (c0_we !== 1'b1) begin errors++; $display("FAIL weo_we got %b exp 1", c0_we); end
        checks++; if (c0_ce !== 1'b0) begin errors++; $display("FAIL weo_wr_ce got %b exp 0", c0_ce); end
        checks++; if (c0_zoe !== 1'b0) begin errors++; $display("FAIL weo_wr_zoe got %b exp 0", c0_zoe); end
        bus(16'h7005, 8'h00, 1'b1);
        checks++; if (c0_zoe !== 1'b1) begin errors++; $display("FAIL weo_rd_zoe got %b exp 1", c0_zoe); end
        checks++; if (c0_ce !== 1'b0) begin errors++; $display("FAIL weo_rd_ce got %b exp 0", c0_ce); end
        bus(16'h7205, 8'h5A, 1'b0);
        checks++; if (c0_we !== 1'b0) begin errors++; $display("FAIL weo_bank1_we got %b exp 0", c0_we); end
    endtask

    task automatic test_banks3();
        bus(16'hA001, 8'hFC, 1'b0);
        checks++; if (d2_prot !== 8'hFC) begin errors++; $display("FAIL b3_prot got %h exp FC", d2_prot); end
        bus(16'h7600, 8'h00, 1'b1);
        checks++; if (c2_ce !== 1'b0) begin errors++; $display("FAIL b3_unmapped_ce got %b exp 0", c2_ce); end
        checks++; if (c2_zoe !== 1'b1) begin errors++; $display("FAIL b3_unmapped_zoe got %b exp 1", c2_zoe); end
        checks++; if (c2_addr !== 11'h600) begin errors++; $display("FAIL b3_addr got %h exp 600", c2_addr); end
        checks++; if (c0_ce !== 1'b1) begin errors++; $display("FAIL b2_7600_ce got %b exp 1", c0_ce); end
        bus(16'h7400, 8'h00, 1'b1);
        checks++; if (c2_ce !== 1'b1) begin errors++; $display("FAIL b3_bank2_ce got %b exp 1", c2_ce); end
        bus(16'h7000, 8'h00, 1'b1);
        checks++; if (c2_ce !== 1'b1) begin errors++; $display("FAIL b3_bank0_ce got %b exp 1", c2_ce); end
    endtask

    task automatic test_rst_priority();
        @(negedge clk);
        cpu_addr = 16'h8000; cpu_data = 8'h55; cpu_rw = 1'b0; cpu_m2 = 1'b1;
        @(negedge clk);
        cpu_m2 = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cpu_rw = 1'b1;
        @(negedge clk);
        checks++; if (d0_ctrl !== 8'h00) begin errors++; $display("FAIL rstpri_ctrl got %h exp 00", d0_ctrl); end
        checks++; if (d0_prot !== 8'h00) begin errors++; $display("FAIL rstpri_prot got %h exp 00", d0_prot); end
    endtask

    task automatic test_lockout();
        bus(16'h8000, 8'h20, 1'b0);
        bus(16'hA001, 8'hF0, 1'b0);
        bus(16'h7000, 8'h11, 1'b0);
        checks++; if (c1_we !== 1'b0) begin errors++; $display("FAIL lock_c3_we got %b exp 0", c1_we); end
        checks++; if (c1_ce !== 1'b1) begin errors++; $display("FAIL lock_c3_ce got %b exp 1", c1_ce); end
        checks++; if (c0_we !== 1'b1) begin errors++; $display("FAIL nolock_c3_we got %b exp 1", c0_we); end
        bus(16'h7000, 8'h22, 1'b0);
        checks++; if (c1_we !== 1'b0) begin errors++; $display("FAIL lock_c4_we got %b exp 0", c1_we); end
        bus(16'h7000, 8'h33, 1'b0);
        checks++; if (c1_we !== 1'b1) begin errors++; $display("FAIL lock_c5_we got %b exp 1", c1_we); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        bus(16'h8000, 8'h20, 1'b0);
        bus(16'hA001, 8'hF0, 1'b0);
        bus(16'h7000, 8'h44, 1'b0);
        checks++; if (c1_we !== 1'b0) begin errors++; $display("FAIL lock_reload_we got %b exp 0", c1_we); end
        checks++; if (c0_we !== 1'b1) begin errors++; $display("FAIL nolock_reload_we got %b exp 1", c0_we); end
    endtask

    task automatic test_sst();
        logic [7:0] exp_ctrl, exp_prot, exp_di33, exp_di32;
        logic       exp_hit;
        exp_ctrl = SST_ON ? 8'h20 : 8'h07;
        exp_prot = SST_ON ? 8'hC0 : 8'h00;
        exp_hit  = SST_ON;
        exp_di33 = SST_ON ? 8'hC0 : 8'hFF;
        exp_di32 = SST_ON ? 8'h20 : 8'hFF;
        sst_act = 1'b1; sst_we_reg = 1'b1; sst_addr = 8'd32; sst_dato = 8'h20;
        bus(16'h8000, 8'h07, 1'b0);
        checks++; if (d0_ctrl !== exp_ctrl) begin errors++; $display("FAIL sst_ctrl got %h exp %h", d0_ctrl, exp_ctrl); end
        sst_addr = 8'd33; sst_dato = 8'hC0;
        bus(16'hA001, 8'hFF, 1'b0);
        checks++; if (d0_prot !== exp_prot) begin errors++; $display("FAIL sst_prot got %h exp %h", d0_prot, exp_prot); end
        @(negedge clk);
        sst_we_reg = 1'b0; sst_addr = 8'd33;
        #1;
        checks++; if (d0_sst_di !== exp_di33) begin errors++; $display("FAIL sst_di33 got %h exp %h", d0_sst_di, exp_di33); end
        checks++; if (d0_sst_hit !== exp_hit) begin errors++; $display("FAIL sst_hit33 got %b exp %b", d0_sst_hit, exp_hit); end
        @(negedge clk); sst_addr = 8'd32; #1;
        checks++; if (d0_sst_di !== exp_di32) begin errors++; $display("FAIL sst_di32 got %h exp %h", d0_sst_di, exp_di32); end
        @(negedge clk); sst_addr = 8'd40; #1;
        checks++; if (d0_sst_di !== 8'hFF) begin errors++; $display("FAIL sst_di40 got %h exp FF", d0_sst_di); end
        checks++; if (d0_sst_hit !== 1'b0) begin errors++; $display("FAIL sst_hit40 got %b exp 0", d0_sst_hit); end
        sst_act = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cpu_addr = 16'h0000; cpu_data = 8'h00; cpu_rw = 1'b1; cpu_m2 = 1'b0;
        sst_act = 1'b0; sst_we_reg = 1'b0; sst_addr = 8'h00; sst_dato = 8'h00;
        test_reset();
        test_basic();
        test_master_off();
        test_we_only();
        test_banks3();
        test_rst_priority();
        test_lockout();
        test_sst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
